// File: rtl/lcd_frame_sequencer.sv
// Sends one 2-line character frame to the LCD transaction layer as address and character transactions.
// Optional build macro LCD_AUTO_REFRESH_EN re-sends the last frame after REFRESH_CYCLES idle cycles.
module lcd_frame_sequencer #(
  parameter int unsigned CHARS_PER_LINE = 16,
  parameter logic [6:0]  LINE1_ADDR     = 7'h00,
  parameter logic [6:0]  LINE2_ADDR     = 7'h40,
  parameter int unsigned TIMEOUT_CYCLES = 200000
`ifdef LCD_AUTO_REFRESH_EN
  , parameter int unsigned REFRESH_CYCLES = 5000000
`endif
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          start,
  input  logic [16*CHARS_PER_LINE-1:0]  frame_data,
  output logic                          do_set_dd_ram_addr,
  output logic [6:0]                    dd_ram_addr,
  output logic                          do_write_data,
  output logic [7:0]                    write_data,
  input  logic                          set_dd_ram_addr_done,
  input  logic                          send_data_done,
  output logic                          busy,
  output logic                          frame_done,
  output logic                          error
);
  localparam int unsigned FW = 16 * CHARS_PER_LINE;
  localparam int unsigned CW = (CHARS_PER_LINE > 1) ? $clog2(CHARS_PER_LINE) : 1;
  localparam int unsigned TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] COL_LAST = CW'(CHARS_PER_LINE - 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    SET_ADDR  = 3'd1,
    WAIT_ADDR = 3'd2,
    SEND_CHAR = 3'd3,
    WAIT_CHAR = 3'd4,
    FINISH    = 3'd5
  } state_t;

  state_t          state_r, state_s;
  logic [FW-1:0]   shift_r, shift_s;
  logic            line_r, line_s;
  logic [CW-1:0]   col_r, col_s;
  logic [TW-1:0]   tmo_r, tmo_s;
  logic            do_addr_r, do_addr_s, do_wr_r, do_wr_s;
  logic [6:0]      addr_r, addr_s;
  logic [7:0]      wdata_r, wdata_s;
  logic            busy_r, busy_s, frame_done_r, frame_done_s, error_r, error_s;
  logic            go_s;
  logic [FW-1:0]   load_s;

`ifdef LCD_AUTO_REFRESH_EN
  localparam int unsigned RW = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
  localparam logic [RW-1:0] REF_LAST = RW'(REFRESH_CYCLES - 1);
  logic [FW-1:0]   frame_r, frame_s;
  logic [RW-1:0]   ref_cnt_r, ref_cnt_s;
  logic            have_frame_r, have_frame_s;
  logic            ref_hit_s;

  // Refresh trigger: idle counter runs only once a frame exists; an external start overrides the replay.
  always_comb begin
    ref_hit_s    = (state_r == IDLE) && have_frame_r && (ref_cnt_r == REF_LAST);
    go_s         = start || ref_hit_s;
    load_s       = start ? frame_data : frame_r;
    frame_s      = (state_r == IDLE && start) ? frame_data : frame_r;
    have_frame_s = have_frame_r || (state_r == IDLE && start);
    if (state_r == IDLE && have_frame_r) begin
      ref_cnt_s = ref_hit_s ? {RW{1'b0}} : ref_cnt_r + RW'(1);
    end else begin
      ref_cnt_s = {RW{1'b0}};
    end
  end

  // Refresh bookkeeping registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      frame_r      <= {FW{1'b0}};
      ref_cnt_r    <= {RW{1'b0}};
      have_frame_r <= 1'b0;
    end else begin
      frame_r      <= frame_s;
      ref_cnt_r    <= ref_cnt_s;
      have_frame_r <= have_frame_s;
    end
  end
`else
  // Frames are sent on external start only.
  always_comb begin
    go_s   = start;
    load_s = frame_data;
  end
`endif

  // Next-state and next-output logic; every output is registered from these values.
  always_comb begin
    state_s      = state_r;
    shift_s      = shift_r;
    line_s       = line_r;
    col_s        = col_r;
    tmo_s        = tmo_r;
    do_addr_s    = 1'b0;
    do_wr_s      = 1'b0;
    addr_s       = addr_r;
    wdata_s      = wdata_r;
    busy_s       = busy_r;
    frame_done_s = 1'b0;
    error_s      = error_r;
    case (state_r)
      IDLE: begin
        if (go_s) begin
          shift_s = load_s;
          error_s = 1'b0;
          busy_s  = 1'b1;
          line_s  = 1'b0;
          col_s   = {CW{1'b0}};
          state_s = SET_ADDR;
        end else begin
          state_s = IDLE;
        end
      end
      SET_ADDR: begin
        do_addr_s = 1'b1;
        addr_s    = line_r ? LINE2_ADDR : LINE1_ADDR;
        tmo_s     = {TW{1'b0}};
        state_s   = WAIT_ADDR;
      end
      WAIT_ADDR: begin
        if (set_dd_ram_addr_done) begin
          col_s   = {CW{1'b0}};
          state_s = SEND_CHAR;
        end else if (tmo_r == TMO_LAST) begin
          error_s = 1'b1;
          busy_s  = 1'b0;
          state_s = IDLE;
        end else begin
          tmo_s = tmo_r + TW'(1);
        end
      end
      SEND_CHAR: begin
        // The working copy is shifted as characters are acknowledged, so the next char is always on top.
        do_wr_s = 1'b1;
        wdata_s = shift_r[FW-1 -: 8];
        tmo_s   = {TW{1'b0}};
        state_s = WAIT_CHAR;
      end
      WAIT_CHAR: begin
        if (send_data_done) begin
          shift_s = {shift_r[FW-9:0], 8'h00};
          if (col_r == COL_LAST) begin
            if (!line_r) begin
              line_s  = 1'b1;
              state_s = SET_ADDR;
            end else begin
              state_s = FINISH;
            end
          end else begin
            col_s   = col_r + CW'(1);
            state_s = SEND_CHAR;
          end
        end else if (tmo_r == TMO_LAST) begin
          error_s = 1'b1;
          busy_s  = 1'b0;
          state_s = IDLE;
        end else begin
          tmo_s = tmo_r + TW'(1);
        end
      end
      FINISH: begin
        frame_done_s = 1'b1;
        busy_s       = 1'b0;
        state_s      = IDLE;
      end
      default: begin
        busy_s  = 1'b0;
        state_s = IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Datapath and output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      shift_r      <= {FW{1'b0}};
      line_r       <= 1'b0;
      col_r        <= {CW{1'b0}};
      tmo_r        <= {TW{1'b0}};
      do_addr_r    <= 1'b0;
      do_wr_r      <= 1'b0;
      addr_r       <= 7'h00;
      wdata_r      <= 8'h00;
      busy_r       <= 1'b0;
      frame_done_r <= 1'b0;
      error_r      <= 1'b0;
    end else begin
      shift_r      <= shift_s;
      line_r       <= line_s;
      col_r        <= col_s;
      tmo_r        <= tmo_s;
      do_addr_r    <= do_addr_s;
      do_wr_r      <= do_wr_s;
      addr_r       <= addr_s;
      wdata_r      <= wdata_s;
      busy_r       <= busy_s;
      frame_done_r <= frame_done_s;
      error_r      <= error_s;
    end
  end

  assign do_set_dd_ram_addr = do_addr_r;
  assign dd_ram_addr        = addr_r;
  assign do_write_data      = do_wr_r;
  assign write_data         = wdata_r;
  assign busy               = busy_r;
  assign frame_done         = frame_done_r;
  assign error              = error_r;
endmodule

// File: tb/tb_lcd_frame_sequencer.sv
// Bench for lcd_frame_sequencer: a transaction-list model predicts every output each cycle,
// a done responder plays the transaction layer; define LCD_AUTO_REFRESH_EN to also exercise refresh.
module tb_lcd_frame_sequencer;
  localparam int TMO = 40;
`ifdef LCD_AUTO_REFRESH_EN
  localparam int REF = 100;
`endif

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         start = 1'b0;
  logic [255:0] frame_data = 256'h0;
  logic         do_set_dd_ram_addr, do_write_data, busy, frame_done, error;
  logic [6:0]   dd_ram_addr;
  logic [7:0]   write_data;
  logic         set_dd_ram_addr_done = 1'b0;
  logic         send_data_done = 1'b0;

  lcd_frame_sequencer #(
    .TIMEOUT_CYCLES(TMO)
`ifdef LCD_AUTO_REFRESH_EN
    , .REFRESH_CYCLES(REF)
`endif
  ) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .frame_data(frame_data),
    .do_set_dd_ram_addr(do_set_dd_ram_addr), .dd_ram_addr(dd_ram_addr),
    .do_write_data(do_write_data), .write_data(write_data),
    .set_dd_ram_addr_done(set_dd_ram_addr_done), .send_data_done(send_data_done),
    .busy(busy), .frame_done(frame_done), .error(error)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- transaction-layer responder ----------------
  int lat = 0;
  int hold_idx = -1;
  bit stray = 1'b0;
  int due = -1;
  int due_kind = 0;
  int stray_due = -1;
  int n_addr = 0;
  int wr_n = 0;
  int fd_n = 0;
  logic [6:0] addr_log[$];
  logic [7:0] wlog[$];

  initial begin : responder
    forever begin
      @(posedge clk); #1;
      set_dd_ram_addr_done = 1'b0;
      send_data_done = 1'b0;
      if (!reset_n) begin
        due = -1;
        stray_due = -1;
      end else begin
        if (frame_done) fd_n++;
        if (do_set_dd_ram_addr) begin
          n_addr++;
          addr_log.push_back(dd_ram_addr);
          due = cyc + lat;
          due_kind = 0;
          if (stray) begin
            stray_due = cyc + 1;
            stray = 1'b0;
          end
        end
        if (do_write_data) begin
          wlog.push_back(write_data);
          if (wr_n != hold_idx) begin
            due = cyc + lat;
            due_kind = 1;
          end
          wr_n++;
        end
        if (due == cyc) begin
          if (due_kind == 0) set_dd_ram_addr_done = 1'b1;
          else send_data_done = 1'b1;
          due = -1;
        end
        if (stray_due == cyc) begin
          send_data_done = 1'b1;
          stray_due = -1;
        end
      end
    end
  end

  // ---------------- behavioural model and compare ----------------
  int         exp_kind[34];
  logic [7:0] exp_val[34];

  function automatic void build(input logic [255:0] f);
    logic [255:0] t;
    for (int n = 0; n < 32; n++) begin
      t = f >> (8 * (31 - n));
      exp_kind[(n < 16) ? n + 1 : n + 2] = 1;
      exp_val[(n < 16) ? n + 1 : n + 2]  = t[7:0];
    end
    exp_kind[0] = 0;  exp_val[0]  = 8'h00;
    exp_kind[17] = 0; exp_val[17] = 8'h40;
  endfunction

  initial begin : compare
    bit m_busy, m_err, n_busy, n_err, waiting, acc, done_hit;
    int next_pulse, pulse_cyc, tx_i, fd_cyc;
    bit is_pulse;
`ifdef LCD_AUTO_REFRESH_EN
    bit have;
    int idle_run;
    logic [255:0] m_frame;
    have = 1'b0; idle_run = 0; m_frame = 256'h0;
`endif
    m_busy = 1'b0; m_err = 1'b0; waiting = 1'b0;
    next_pulse = -1; pulse_cyc = -1; tx_i = 0; fd_cyc = -1;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        chk("rst_do_set", {31'd0, do_set_dd_ram_addr}, 32'd0);
        chk("rst_addr", {25'd0, dd_ram_addr}, 32'd0);
        chk("rst_do_wr", {31'd0, do_write_data}, 32'd0);
        chk("rst_wdata", {24'd0, write_data}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_fdone", {31'd0, frame_done}, 32'd0);
        chk("rst_error", {31'd0, error}, 32'd0);
        m_busy = 1'b0; m_err = 1'b0; waiting = 1'b0;
        next_pulse = -1; fd_cyc = -1; tx_i = 0;
`ifdef LCD_AUTO_REFRESH_EN
        have = 1'b0; idle_run = 0;
`endif
      end else begin
        if (cyc == fd_cyc) m_busy = 1'b0;
        if (cyc == next_pulse) begin
          waiting = 1'b1;
          pulse_cyc = cyc;
        end
        is_pulse = waiting && (pulse_cyc == cyc);
        chk("do_set_dd_ram_addr", {31'd0, do_set_dd_ram_addr}, {31'd0, is_pulse && exp_kind[tx_i] == 0});
        chk("do_write_data", {31'd0, do_write_data}, {31'd0, is_pulse && exp_kind[tx_i] == 1});
        chk("frame_done", {31'd0, frame_done}, {31'd0, cyc == fd_cyc});
        chk("busy", {31'd0, busy}, {31'd0, m_busy});
        chk("error", {31'd0, error}, {31'd0, m_err});
        if (waiting && exp_kind[tx_i] == 0) chk("dd_ram_addr", {25'd0, dd_ram_addr}, {24'd0, exp_val[tx_i]});
        if (waiting && exp_kind[tx_i] == 1) chk("write_data", {24'd0, write_data}, {24'd0, exp_val[tx_i]});
        n_busy = m_busy; n_err = m_err; acc = 1'b0;
        if (waiting) begin
          done_hit = (exp_kind[tx_i] == 0) ? set_dd_ram_addr_done : send_data_done;
          if (done_hit) begin
            waiting = 1'b0;
            tx_i++;
            if (tx_i == 34) fd_cyc = cyc + 2;
            else next_pulse = cyc + 2;
          end else if (cyc - pulse_cyc == TMO - 1) begin
            waiting = 1'b0;
            n_busy = 1'b0;
            n_err = 1'b1;
          end
        end else if (!m_busy) begin
          if (start) begin
            build(frame_data);
            acc = 1'b1;
`ifdef LCD_AUTO_REFRESH_EN
            m_frame = frame_data;
            have = 1'b1;
          end else if (have && idle_run == REF - 1) begin
            build(m_frame);
            acc = 1'b1;
`endif
          end
          if (acc) begin
            n_busy = 1'b1; n_err = 1'b0; tx_i = 0; next_pulse = cyc + 2;
          end
        end
`ifdef LCD_AUTO_REFRESH_EN
        if (m_busy || acc) idle_run = 0;
        else if (have) idle_run++;
`endif
        m_busy = n_busy;
        m_err = n_err;
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic do_start(input logic [255:0] f);
    frame_data = f;
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic wait_idle(input int bound, input string tag);
    int n = 0;
    while (busy && n < bound) begin
      step();
      n++;
    end
    chk(tag, {31'd0, busy}, 32'd0);
    step();
  endtask

  task automatic clr_logs();
    n_addr = 0; wr_n = 0; fd_n = 0;
    addr_log.delete();
    wlog.delete();
  endtask

  logic [255:0] f1, f2, f3;

  initial begin : stimulus
    f1 = {"MFG:20 TYP:20   ", "CAP:15          "};
    f2 = {"0123456789ABCDEF", "abcdefghijklmnop"};
    f3 = {"ZZZZZZZZZZZZZZZZ", "YYYYYYYYYYYYYYYY"};
    repeat (3) step();
    reset_n = 1'b1;
    step();

    // 1: zero-wait done model
    clr_logs(); lat = 0;
    do_start(f1);
    wait_idle(200, "t1_busy_timeout");
    chk("t1_pulses", n_addr + wr_n, 34);
    chk("t1_addr0", {25'd0, addr_log[0]}, 32'h00);
    chk("t1_addr1", {25'd0, addr_log[1]}, 32'h40);
    chk("t1_char0", {24'd0, wlog[0]}, 32'h4D);
    chk("t1_char4", {24'd0, wlog[4]}, 32'h32);
    chk("t1_char15", {24'd0, wlog[15]}, 32'h20);
    chk("t1_char16", {24'd0, wlog[16]}, 32'h43);
    chk("t1_fdone", fd_n, 1);

    // 2: 7-cycle done latency, frame_data changed mid-frame
    clr_logs(); lat = 7;
    do_start(f2);
    repeat (10) step();
    frame_data = f3;
    wait_idle(600, "t2_busy_timeout");
    chk("t2_pulses", n_addr + wr_n, 34);
    chk("t2_char31", {24'd0, wlog[31]}, 32'h70);

    // 3: start while busy and a stray send_data_done in WAIT_ADDR
    clr_logs(); lat = 3; stray = 1'b1;
    do_start(f1);
    repeat (4) step();
    do_start(f3);
    wait_idle(400, "t3_busy_timeout");
    chk("t3_pulses", n_addr + wr_n, 34);
    chk("t3_char0", {24'd0, wlog[0]}, 32'h4D);

    // 4: withhold done on char 5 -> timeout, then recover
    clr_logs(); lat = 1; hold_idx = 5;
    do_start(f2);
    wait_idle(300, "t4_busy_timeout");
    chk("t4_error", {31'd0, error}, 32'd1);
    chk("t4_no_fdone", fd_n, 0);
    chk("t4_writes", wr_n, 6);
    clr_logs(); hold_idx = -1;
    do_start(f1);
    wait_idle(300, "t4b_busy_timeout");
    chk("t4b_error_clr", {31'd0, error}, 32'd0);
    chk("t4b_fdone", fd_n, 1);

    // 5: reset while waiting on char 20
    clr_logs(); lat = 5;
    do_start(f2);
    for (int n = 0; n < 500 && wr_n < 21; n++) step();
    chk("t5_reached_char20", {31'd0, wr_n >= 21}, 32'd1);
    reset_n = 1'b0;
    #1;
    chk("t5_rst_busy", {31'd0, busy}, 32'd0);
    chk("t5_rst_do_wr", {31'd0, do_write_data}, 32'd0);
    repeat (3) step();
    reset_n = 1'b1;
    clr_logs();
    repeat (30) step();
    chk("t5_quiet", n_addr + wr_n, 0);
    do_start(f3);
    wait_idle(400, "t5_busy_timeout");
    chk("t5_pulses", n_addr + wr_n, 34);
    chk("t5_char0", {24'd0, wlog[0]}, 32'h5A);

`ifdef LCD_AUTO_REFRESH_EN
    // 6: auto refresh replays the last frame; a coincident start wins
    clr_logs(); lat = 0;
    begin
      int n = 0;
      while (!frame_done && n < 400) begin
        step();
        n++;
      end
    end
    chk("t6_refresh_fdone", {31'd0, frame_done}, 32'd1);
    chk("t6_refresh_char0", {24'd0, wlog[0]}, 32'h5A);
    repeat (REF - 1) step();
    clr_logs();
    do_start(f1);
    wait_idle(400, "t6_busy_timeout");
    chk("t6_new_pulses", n_addr + wr_n, 34);
    chk("t6_new_char0", {24'd0, wlog[0]}, 32'h4D);
`endif

    repeat (5) step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
